// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: bundles the CPU fetch port, storage array port and memory block port of the controller
interface icache_ctrl_if #(
    parameter int BLOCK_SIZE = 4,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                             cpu_req;
    logic [31:0]                      cpu_addr;
    logic                             cpu_ready;
    logic                             cpu_valid;
    logic [WORD_WIDTH-1:0]            cpu_rdata;
    logic                             cpu_error;
    logic                             st_read;
    logic                             st_write;
    logic [31:0]                      st_address;
    logic [WORD_WIDTH*BLOCK_SIZE-1:0] st_write_block;
    logic [WORD_WIDTH-1:0]            st_read_data;
    logic                             st_hit;
    logic                             mem_req;
    logic [31:0]                      mem_addr;
    logic                             mem_ready;
    logic [WORD_WIDTH*BLOCK_SIZE-1:0] mem_rdata;
    logic [CNT_WIDTH-1:0]             hit_count;
    logic [CNT_WIDTH-1:0]             miss_count;

    modport master (
        output cpu_req, cpu_addr, st_read_data, st_hit, mem_ready, mem_rdata,
        input  cpu_ready, cpu_valid, cpu_rdata, cpu_error, st_read, st_write, st_address,
               st_write_block, mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  cpu_req, cpu_addr, st_read_data, st_hit, mem_ready, mem_rdata,
        output cpu_ready, cpu_valid, cpu_rdata, cpu_error, st_read, st_write, st_address,
               st_write_block, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: sequences lookup, block refill and word forwarding for a direct-mapped instruction cache
module icache_ctrl #(
    parameter int BLOCK_SIZE = 4,
    parameter int WORD_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 24,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input logic        clk,
    input logic        reset,
    icache_ctrl_if.slave bus
);
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int TW          = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    if (INDEX_BITS + TAG_BITS + OFFSET_BITS > 32) begin : g_geom_check
        $error("icache_ctrl: index+tag+offset exceeds the 32-bit address");
    end

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL} state_t;

    state_t                           r_state;
    logic [31:0]                      r_addr;
    logic [WORD_WIDTH*BLOCK_SIZE-1:0] r_block;
    logic [TW-1:0]                    r_tmo;
    logic                             r_valid;
    logic                             r_error;
    logic [WORD_WIDTH-1:0]            r_rdata;
    logic [CNT_WIDTH-1:0]             r_hits;
    logic [CNT_WIDTH-1:0]             r_misses;
    logic                             w_accept;
    logic                             w_timeout;

    assign w_accept  = r_state == IDLE && bus.cpu_req;
    assign w_timeout = TIMEOUT != 0 && !bus.mem_ready && r_tmo == TW'(TIMEOUT - 1);

    assign bus.cpu_ready      = r_state == IDLE;
    assign bus.cpu_valid      = r_valid;
    assign bus.cpu_error      = r_error;
    assign bus.cpu_rdata      = r_rdata;
    assign bus.st_read        = w_accept;
    assign bus.st_write       = r_state == FILL;
    assign bus.st_address     = w_accept ? bus.cpu_addr : r_addr;
    assign bus.st_write_block = r_block;
    assign bus.mem_req        = r_state == MISS;
    assign bus.mem_addr       = {r_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign bus.hit_count      = r_hits;
    assign bus.miss_count     = r_misses;

    // Controller FSM: lookup, refill wait with timeout, fill and registered CPU response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_block  <= '0;
            r_tmo    <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_rdata  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: if (bus.cpu_req) begin
                    r_addr  <= bus.cpu_addr;
                    r_state <= LOOKUP;
                end
                LOOKUP: if (bus.st_hit) begin
                    r_rdata <= bus.st_read_data;
                    r_valid <= 1'b1;
                    r_hits  <= r_hits + 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_misses <= r_misses + 1'b1;
                    r_tmo    <= '0;
                    r_state  <= MISS;
                end
                MISS: if (bus.mem_ready) begin
                    r_block <= bus.mem_rdata;
                    r_state <= FILL;
                end else if (w_timeout) begin
                    r_valid <= 1'b1;
                    r_error <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
                FILL: begin
                    r_rdata <= r_block[r_addr[OFFSET_BITS-1:0]*WORD_WIDTH +: WORD_WIDTH];
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench with storage and memory models around icache_ctrl
module tb_icache_ctrl;
    localparam int BS = 4;
    localparam int WW = 32;
    localparam int CW = 16;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        bit          never;
        logic [31:0] data;
        bit          err;
        int          clat;
        logic [31:0] maddr;
        int          mreq;
        int          stw;
        int          hits;
        int          misses;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    icache_ctrl_if #(.BLOCK_SIZE(BS), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus();

    icache_ctrl #(
        .BLOCK_SIZE(BS), .WORD_WIDTH(WW), .INDEX_BITS(4), .TAG_BITS(24),
        .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    bit   mon_en = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] base, input int i);
        return base == 32'h104 ? 32'(32'h11111111 * (i + 1)) : {base[15:0], 16'(i)};
    endfunction

    always @(posedge clk) cyc++;

    // Storage array model: registered read one cycle after st_read, block write on st_write
    bit          s_val[16];
    logic [25:0] s_tag[16];
    logic [127:0] s_data[16];
    always @(posedge clk) begin
        if (bus.st_read) begin
            bus.st_hit       <= s_val[bus.st_address[5:2]] && s_tag[bus.st_address[5:2]] == bus.st_address[31:6];
            bus.st_read_data <= s_data[bus.st_address[5:2]][bus.st_address[1:0]*WW +: WW];
        end
        if (bus.st_write) begin
            s_val[bus.st_address[5:2]]  <= 1'b1;
            s_tag[bus.st_address[5:2]]  <= bus.st_address[31:6];
            s_data[bus.st_address[5:2]] <= bus.st_write_block;
        end
    end

    // Memory model: answers mem_req after mem_lat wait cycles unless mem_never
    logic mem_rdy_q = 0;
    logic force_rdy = 0;
    bit   mem_never = 0;
    int   mem_lat = 0;
    int   wcnt = 0;
    assign bus.mem_ready = mem_rdy_q | force_rdy;
    always @(negedge clk) begin
        mem_rdy_q = bus.mem_req && !mem_never && wcnt == mem_lat;
        for (int i = 0; i < BS; i++) bus.mem_rdata[i*WW +: WW] = mword(bus.mem_addr, i);
        wcnt = bus.mem_req ? wcnt + 1 : 0;
    end

    // Monitor: protocol checks and scoreboard pops on every cpu_valid
    int          mreq_n = 0;
    int          stw_n = 0;
    logic [31:0] maddr_seen = 0;
    logic        pmreq = 0;
    logic [31:0] pmaddr = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (bus.st_read | bus.st_write | bus.mem_req)
                chk("strobe_exclusive", 64'($onehot0({bus.st_read, bus.st_write, bus.mem_req})), 1);
            if (bus.mem_req) begin
                mreq_n++;
                maddr_seen = bus.mem_addr;
                if (pmreq) chk("mem_addr_stable", bus.mem_addr, pmaddr);
            end
            if (bus.st_write) stw_n++;
            pmreq  = bus.mem_req;
            pmaddr = bus.mem_addr;
            if (bus.cpu_valid) begin
                if (q.size() == 0) chk("spurious_valid", bus.cpu_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("cpu_rdata", bus.cpu_rdata, e.data);
                    chk("cpu_error", bus.cpu_error, e.err);
                    chk("valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        chk("drain", q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int m0;
        int s0;
        m0 = mreq_n;
        s0 = stw_n;
        mem_lat   = v.lat;
        mem_never = v.never;
        chk("accept_ready", bus.cpu_ready, 1);
        bus.cpu_req  = 1;
        bus.cpu_addr = v.addr;
        q.push_back('{data: v.data, err: v.err, cyc: cyc + v.clat});
        @(negedge clk);
        bus.cpu_req = 0;
        drain();
        if (v.mreq != 0) chk("mem_addr", maddr_seen, v.maddr);
        chk("mem_req_cycles", mreq_n - m0, v.mreq);
        chk("st_write_pulses", stw_n - s0, v.stw);
        chk("hit_count", bus.hit_count, v.hits);
        chk("miss_count", bus.miss_count, v.misses);
        mem_never = 0;
    endtask

    vec_t        vecs[6];
    logic [31:0] b2b[4];

    initial begin
        int m0;
        int s0;
        vecs = '{
            '{32'h104, 3, 0, 32'h11111111, 0,  7, 32'h104, 4, 1, 0, 1},
            '{32'h106, 0, 0, 32'h33333333, 0,  2, 32'h0,   0, 0, 1, 1},
            '{32'h204, 0, 0, 32'h02040000, 0,  4, 32'h204, 1, 1, 1, 2},
            '{32'h104, 1, 0, 32'h11111111, 0,  5, 32'h104, 2, 1, 1, 3},
            '{32'h30B, 2, 0, 32'h03080003, 0,  6, 32'h308, 3, 1, 1, 4},
            '{32'h400, 0, 1, 32'h03080003, 1, 10, 32'h400, 8, 0, 1, 5}
        };
        b2b = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        bus.cpu_req  = 0;
        bus.cpu_addr = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_cpu_ready", bus.cpu_ready, 1);
        chk("rst_cpu_valid", bus.cpu_valid, 0);
        chk("rst_cpu_error", bus.cpu_error, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_st_read", bus.st_read, 0);
        chk("rst_st_write", bus.st_write, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_st_address", bus.st_address, 0);
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        mon_en = 1;
        foreach (vecs[i]) run_vec(vecs[i]);
        mem_never    = 1;
        bus.cpu_req  = 1;
        bus.cpu_addr = 32'h500;
        @(negedge clk);
        bus.cpu_req = 0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) @(negedge clk);
        chk("rst_in_miss_reached", bus.mem_req, 1);
        @(negedge clk);
        s0 = stw_n;
        reset = 1;
        @(negedge clk);
        reset = 0;
        force_rdy = 1;
        @(negedge clk);
        force_rdy = 0;
        mem_never = 0;
        repeat (4) @(negedge clk);
        chk("rst_abort_no_write", stw_n - s0, 0);
        chk("rst_abort_hits", bus.hit_count, 0);
        chk("rst_abort_misses", bus.miss_count, 0);
        chk("rst_abort_ready", bus.cpu_ready, 1);
        chk("rst_abort_valid", bus.cpu_valid, 0);
        m0 = mreq_n;
        bus.cpu_req = 1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_addr = 32'h104 + i;
            q.push_back('{data: b2b[i], err: 1'b0, cyc: cyc + 2});
            @(negedge clk);
            for (int k = 0; k < 10 && !bus.cpu_ready; k++) @(negedge clk);
        end
        bus.cpu_req = 0;
        drain();
        chk("b2b_hit_count", bus.hit_count, 4);
        chk("b2b_miss_count", bus.miss_count, 0);
        chk("b2b_no_mem_req", mreq_n - m0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencing controller for the direct-mapped instruction cache storage array. It accepts one CPU fetch at a time, drives the storage lookup, and on a miss fetches the aligned block from memory and writes it into storage. It forwards the requested word to the CPU and keeps hit/miss statistics. It sits between the CPU fetch port, the cache storage array and the memory block interface.

## Interface
- BLOCK_SIZE, 4, words per block (power of two, ≥2); OFFSET_BITS = log2(BLOCK_SIZE)
- WORD_WIDTH, 32, instruction width
- INDEX_BITS, 4, storage index width (passed through; controller does not decode index/tag)
- TAG_BITS, 24, storage tag width (passed through)
- TIMEOUT, 64, max cycles waiting for mem_ready; 0 disables timeout
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  fetch request
- cpu_addr  in  32  word address, sampled at acceptance
- cpu_ready  out  1  high only in IDLE; accept = cpu_req & cpu_ready
- cpu_valid  out  1  one-cycle response pulse
- cpu_rdata  out  WORD_WIDTH  fetched word, valid with cpu_valid, holds otherwise
- cpu_error  out  1  with cpu_valid: memory timeout, cpu_rdata not updated
- st_read  out  1  storage read strobe
- st_write  out  1  storage block write strobe
- st_address  out  32  storage address
- st_write_block  out  WORD_WIDTH*BLOCK_SIZE  refill block, word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- st_read_data  in  WORD_WIDTH  storage word, valid the cycle after st_read
- st_hit  in  1  storage hit flag, valid the cycle after st_read
- mem_req  out  1  block fetch request
- mem_addr  out  32  block-aligned address (low OFFSET_BITS zero)
- mem_ready  in  1  response strobe; mem_rdata valid when high
- mem_rdata  in  WORD_WIDTH*BLOCK_SIZE  returned block
- hit_count, miss_count  out  CNT_WIDTH  statistics, wrap on overflow

## Operation
- States: IDLE, LOOKUP, MISS, FILL.
- IDLE: cpu_ready=1. On accept, latch addr_q=cpu_addr. Drive st_read=1 and st_address=cpu_addr combinationally in the same cycle. Go to LOOKUP.
- LOOKUP: st_address=addr_q. If st_hit: cpu_rdata<=st_read_data, cpu_valid<=1, hit_count+1, go to IDLE. Else: miss_count+1, clear timeout counter, go to MISS. st_read_data on a miss is never propagated.
- MISS: mem_req=1, mem_addr={addr_q[31:OFFSET_BITS], 0}. Held stable until mem_ready. On mem_ready: latch block_q=mem_rdata and go to FILL. mem_ready in the first MISS cycle is accepted. mem_ready outside MISS is ignored.
- Timeout (TIMEOUT>0): counter increments on each MISS cycle without mem_ready. When the count reaches TIMEOUT-1 and mem_ready is still low: cpu_valid<=1, cpu_error<=1, mem_req drops, no storage write, go to IDLE. mem_ready in the same cycle as timeout wins (normal fill).
- FILL: st_write=1, st_address=addr_q, st_write_block=block_q. Forward cpu_rdata<=block_q word[addr_q[OFFSET_BITS-1:0]] and cpu_valid<=1. Go to IDLE.
- A conflicting block (same index, different tag) is overwritten without writeback (read-only cache).
- st_read, st_write and mem_req are never high simultaneously.
- cpu_req is ignored while not in IDLE. No request queueing.

## Timing
- Reset values: state IDLE, cpu_ready=1 (reset follows IDLE), cpu_valid=0, cpu_error=0, cpu_rdata=0, st_read=0, st_write=0, mem_req=0, mem_addr=0, st_address=0, hit_count=0, miss_count=0.
- Reset mid-operation aborts in one edge: no FILL write, and a pending memory response is discarded.
- Hit: accept in cycle 0, cpu_valid in cycle 2.
- Miss: with mem_ready in cycle 2+L (L≥0 cycles of wait), FILL is in cycle 3+L and cpu_valid is in cycle 4+L.
- The earliest next accept is the cycle in which cpu_valid is high (state is already IDLE).
- cpu_valid and cpu_error are registered and last exactly one cycle.

## Test plan
- Cold miss: accept 0x0000_0104; memory returns {0x44444444,0x33333333,0x22222222,0x11111111} after 3 wait cycles -> mem_addr=0x0000_0104, st_write pulse, cpu_rdata=0x11111111, miss_count=1.
- Hit after fill: accept 0x0000_0106 -> cpu_valid two cycles later, cpu_rdata=0x33333333, hit_count=1, mem_req never asserted.
- Conflict: fill 0x0000_0104, then access 0x0000_0204 (same index, new tag) -> miss and refill. Re-access 0x0000_0104 -> miss again; miss_count=3.
- Timeout (TIMEOUT=8): memory never responds -> mem_req high for 8 cycles, then cpu_valid+cpu_error, no st_write, cpu_rdata unchanged.
- Reset asserted in MISS, then mem_ready after reset -> no st_write, cpu_valid stays 0, counters 0, cpu_ready=1.
- Back-to-back: cpu_req held high across four hits in the same block -> one response every 2 cycles, in order, hit_count=4.
